dsp_mac_slice_gen: RTL and testbench

Parametrised successor to the fixed 18x18/48-bit DSP slice. Generic signed pre-add/multiply/post-add MAC with configurable operand and accumulator widths and selectable pipeline depth. Adds behaviour the fixed slice lacks:
- valid tracking, with bubbles that leave the accumulator untouched
- optional saturation
- a sticky overflow flag

Sits in the datapath as a drop-in cascadable MAC, chained through PCIN/PCOUT.

---
 rtl/dsp_gen_pkg.sv | 27 ++
 rtl/dsp_mac_slice_gen_pipe_stage.sv | 31 +++
 rtl/dsp_mac_slice_gen.sv | 140 ++++++++++++++
 tb/tb_dsp_mac_slice_gen.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_gen_pkg.sv
// Shared opmode field positions, Z-select encodings and saturation limits
// for the generic pre-add/multiply/post-add MAC slice.
package dsp_gen_pkg;

    localparam int OP_PREADD  = 0;
    localparam int OP_PRESUB  = 1;
    localparam int OP_ZSEL_LO = 2;
    localparam int OP_ZSEL_HI = 3;
    localparam int OP_POSTSUB = 4;

    localparam logic [1:0] Z_ZERO = 2'b00;
    localparam logic [1:0] Z_P    = 2'b01;
    localparam logic [1:0] Z_C    = 2'b10;
    localparam logic [1:0] Z_PCIN = 2'b11;

    // Wide enough for any sane accumulator; callers truncate to their width.
    localparam int SAT_MAXW = 128;

    function automatic logic [SAT_MAXW-1:0] sat_max(input int unsigned w);
        return (SAT_MAXW'(1) << (w - 1)) - SAT_MAXW'(1);
    endfunction

    function automatic logic [SAT_MAXW-1:0] sat_min(input int unsigned w);
        return SAT_MAXW'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/dsp_mac_slice_gen_pipe_stage.sv
// Optional pipeline register with clock enable and synchronous reset;
// PRESENT=0 turns it into a wire so the caller's stage count stays parametric.
module pipe_stage #(
    parameter int W       = 1,
    parameter bit PRESENT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (PRESENT) begin : g_reg
            logic [W-1:0] r;
            always_ff @(posedge clk) begin
                if (rst)
                    r <= '0;
                else if (ce)
                    r <= d;
            end
            assign q = r;
        end else begin : g_bypass
            logic unused_ok;
            assign unused_ok = ^{clk, rst, ce};
            assign q = d;
        end
    endgenerate

endmodule

// File: rtl/dsp_mac_slice_gen.sv
// Cascadable signed MAC: optional input and multiplier registers, then an always-present
// P stage. Valid bits ride alongside the data so bubbles never disturb the accumulator.
module dsp_mac_slice_gen
    import dsp_gen_pkg::*;
#(
    parameter int W_A      = 18,
    parameter int W_B      = 18,
    parameter int W_P      = 48,
    parameter bit INREG    = 1'b1,
    parameter bit MREG     = 1'b1,
    parameter bit SATURATE = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic [4:0]           opmode,
    input  logic [W_A-1:0]       A,
    input  logic [W_B-1:0]       B,
    input  logic [W_B-1:0]       D,
    input  logic [W_P-1:0]       C,
    input  logic [W_P-1:0]       PCIN,
    output logic                 out_valid,
    output logic [W_P-1:0]       P,
    output logic [W_P-1:0]       PCOUT,
    output logic [W_A+W_B-1:0]   M,
    output logic                 overflow,
    output logic                 overflow_sticky
);

    localparam int W_M  = W_A + W_B;
    localparam int W_IN = 1 + 5 + W_A + 2 * W_B + W_P;
    localparam int W_MS = 1 + 1 + 2 + W_P + W_M;
    localparam logic [W_P-1:0] P_MAX = W_P'(sat_max(W_P));
    localparam logic [W_P-1:0] P_MIN = W_P'(sat_min(W_P));

    logic [W_IN-1:0]          in_q;
    logic                     v1;
    logic [4:0]               op1;
    logic signed [W_A-1:0]    a1;
    logic signed [W_B-1:0]    b1;
    logic signed [W_B-1:0]    d1;
    logic [W_P-1:0]           c1;
    logic signed [W_B-1:0]    pa;
    logic signed [W_M-1:0]    m_comb;

    logic [W_MS-1:0]          ms_q;
    logic                     v2;
    logic                     sub2;
    logic [1:0]               zsel2;
    logic [W_P-1:0]           c2;
    logic [W_M-1:0]           m2;

    logic [W_P-1:0]           p_r;
    logic                     vout_r;
    logic                     ovf_r;
    logic                     sticky_r;
    logic [W_P-1:0]           z;
    logic [W_P:0]             s;
    logic                     ovf;
    logic [W_P-1:0]           p_next;

    pipe_stage #(.W(W_IN), .PRESENT(INREG)) u_in_stage (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .d   ({in_valid, opmode, A, B, D, C}),
        .q   (in_q)
    );

    assign {v1, op1, a1, b1, d1, c1} = in_q;

    // Pre-adder result wraps to W_B bits before it reaches the multiplier.
    always_comb begin
        pa = b1;
        if (op1[OP_PREADD])
            pa = op1[OP_PRESUB] ? (d1 - b1) : (d1 + b1);
    end

    assign m_comb = a1 * pa;

    pipe_stage #(.W(W_MS), .PRESENT(MREG)) u_m_stage (
        .clk (clk),
        .rst (rst),
        .ce  (ce),
        .d   ({v1, op1[OP_POSTSUB], op1[OP_ZSEL_HI:OP_ZSEL_LO], c1, m_comb}),
        .q   (ms_q)
    );

    assign {v2, sub2, zsel2, c2, m2} = ms_q;

    always_comb begin
        z = '0;
        case (zsel2)
            Z_ZERO:  z = '0;
            Z_P:     z = p_r;
            Z_C:     z = c2;
            Z_PCIN:  z = PCIN;
            default: z = '0;
        endcase
    end

    // One guard bit above W_P exposes signed overflow of the post-adder.
    always_comb begin
        s = '0;
        if (sub2)
            s = {z[W_P-1], z} - {{(W_P + 1 - W_M){m2[W_M-1]}}, m2};
        else
            s = {z[W_P-1], z} + {{(W_P + 1 - W_M){m2[W_M-1]}}, m2};
    end

    assign ovf    = s[W_P] ^ s[W_P-1];
    assign p_next = (SATURATE && ovf) ? (s[W_P] ? P_MIN : P_MAX) : s[W_P-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            p_r      <= '0;
            vout_r   <= 1'b0;
            ovf_r    <= 1'b0;
            sticky_r <= 1'b0;
        end else if (ce) begin
            vout_r <= v2;
            if (v2) begin
                p_r      <= p_next;
                ovf_r    <= ovf;
                sticky_r <= sticky_r | ovf;
            end else begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign out_valid       = vout_r;
    assign P               = p_r;
    assign PCOUT           = p_r;
    assign M               = m2;
    assign overflow        = ovf_r;
    assign overflow_sticky = sticky_r;

endmodule

// File: tb/tb_dsp_mac_slice_gen.sv
// Directed bench: default slice, a saturating slice and an unregistered slice share one stimulus
// stream; each scenario task checks hand-computed results on the relevant instance.
module tb_dsp_mac_slice_gen;

    logic               clk = 1'b0;
    logic               rst;
    logic               ce;
    logic               in_valid;
    logic [4:0]         opmode;
    logic [17:0]        a;
    logic [17:0]        b;
    logic [17:0]        d;
    logic [47:0]        c;
    logic [47:0]        pcin;

    logic               ov0, ov1, ov2;
    logic [47:0]        p0, p1, p2, pc0, pc1, pc2;
    logic [35:0]        m0, m1, m2;
    logic               of0, of1, of2, st0, st1, st2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dsp_mac_slice_gen u_def (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .opmode(opmode),
        .A(a), .B(b), .D(d), .C(c), .PCIN(pcin),
        .out_valid(ov0), .P(p0), .PCOUT(pc0), .M(m0), .overflow(of0), .overflow_sticky(st0)
    );

    dsp_mac_slice_gen #(.SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .opmode(opmode),
        .A(a), .B(b), .D(d), .C(c), .PCIN(pcin),
        .out_valid(ov1), .P(p1), .PCOUT(pc1), .M(m1), .overflow(of1), .overflow_sticky(st1)
    );

    dsp_mac_slice_gen #(.INREG(1'b0), .MREG(1'b0)) u_fast (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .opmode(opmode),
        .A(a), .B(b), .D(d), .C(c), .PCIN(pcin),
        .out_valid(ov2), .P(p2), .PCOUT(pc2), .M(m2), .overflow(of2), .overflow_sticky(st2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input int av, input int bv, input int dv);
        in_valid = v;
        opmode   = op;
        a        = 18'(av);
        b        = 18'(bv);
        d        = 18'(dv);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++; if (p0 !== 48'd0)  begin n_err++; $display("FAIL reset_p: got %0h want 0", p0); end
        n_vec++; if (pc0 !== 48'd0) begin n_err++; $display("FAIL reset_pcout: got %0h want 0", pc0); end
        n_vec++; if (m0 !== 36'd0)  begin n_err++; $display("FAIL reset_m: got %0h want 0", m0); end
        n_vec++; if (ov0 !== 1'b0)  begin n_err++; $display("FAIL reset_out_valid: got %b want 0", ov0); end
        n_vec++; if (of0 !== 1'b0)  begin n_err++; $display("FAIL reset_overflow: got %b want 0", of0); end
        n_vec++; if (st0 !== 1'b0)  begin n_err++; $display("FAIL reset_sticky: got %b want 0", st0); end
    endtask

    task automatic test_defaults();
        drive(1'b1, 5'b00000, 3, 4, 0);
        tick();
        in_valid = 1'b0;
        n_vec++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL dflt_lat1: out_valid %b want 0", ov0); end
        n_vec++; if (ov2 !== 1'b1 || p2 !== 48'd12) begin n_err++; $display("FAIL fast_lat1: v=%b p=%0d want v=1 p=12", ov2, p2); end
        tick();
        n_vec++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL dflt_lat2: out_valid %b want 0", ov0); end
        tick();
        n_vec++; if (ov0 !== 1'b1) begin n_err++; $display("FAIL dflt_lat3: out_valid %b want 1", ov0); end
        n_vec++; if (p0 !== 48'd12) begin n_err++; $display("FAIL dflt_p: got %0d want 12", p0); end
        n_vec++; if (m0 !== 36'd12) begin n_err++; $display("FAIL dflt_m: got %0d want 12", m0); end
        n_vec++; if (of0 !== 1'b0) begin n_err++; $display("FAIL dflt_ovf: got %b want 0", of0); end
        tick();
        n_vec++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL dflt_pulse: out_valid %b want 0", ov0); end
    endtask

    task automatic test_preadd();
        logic [47:0] exp_p;
        drive(1'b1, 5'b00011, -2, 3, 10);
        tick();
        drive(1'b1, 5'b00011, -2, 1, -131072);
        tick();
        in_valid = 1'b0;
        tick();
        exp_p = -48'sd14;
        n_vec++; if (ov0 !== 1'b1 || p0 !== exp_p) begin n_err++; $display("FAIL presub: v=%b p=%0h want v=1 p=%0h", ov0, p0, exp_p); end
        tick();
        exp_p = -48'sd262142;
        n_vec++; if (ov0 !== 1'b1 || p0 !== exp_p) begin n_err++; $display("FAIL presub_wrap: v=%b p=%0h want v=1 p=%0h", ov0, p0, exp_p); end
        tick();
    endtask

    task automatic test_accumulate();
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc == 0)
                drive(1'b1, 5'b00000, 1, 5, 0);
            else if (cyc <= 4)
                drive(1'b1, 5'b00100, 1, 5, 0);
            else
                drive(1'b0, 5'b00100, 1, 5, 0);
            tick();
            if (cyc >= 2) begin
                if (cyc - 2 <= 4) begin
                    n_vec++;
                    if (ov0 !== 1'b1 || p0 !== 48'(5 * (cyc - 1))) begin
                        n_err++; $display("FAIL acc_%0d: v=%b p=%0d want v=1 p=%0d", cyc - 2, ov0, p0, 5 * (cyc - 1));
                    end
                end else begin
                    n_vec++;
                    if (ov0 !== 1'b0 || p0 !== 48'd25) begin
                        n_err++; $display("FAIL acc_bubble: v=%b p=%0d want v=0 p=25", ov0, p0);
                    end
                end
            end
        end
    endtask

    task automatic test_saturation();
        c = 48'h7FFF_FFFF_FFF6;
        drive(1'b1, 5'b01000, 0, 0, 0);
        tick();
        drive(1'b1, 5'b00100, 1, 100, 0);
        tick();
        in_valid = 1'b0;
        tick();
        n_vec++; if (p0 !== 48'h7FFF_FFFF_FFF6 || of0 !== 1'b0) begin n_err++; $display("FAIL sat_load: p=%0h ovf=%b want 7ffffffffff6 0", p0, of0); end
        tick();
        n_vec++; if (p0 !== 48'h8000_0000_005A || of0 !== 1'b1 || st0 !== 1'b1) begin
            n_err++; $display("FAIL wrap_ovf: p=%0h ovf=%b st=%b want 80000000005a 1 1", p0, of0, st0);
        end
        n_vec++; if (p1 !== 48'h7FFF_FFFF_FFFF || of1 !== 1'b1 || st1 !== 1'b1) begin
            n_err++; $display("FAIL sat_clamp: p=%0h ovf=%b st=%b want 7fffffffffff 1 1", p1, of1, st1);
        end
        tick();
        n_vec++; if (ov1 !== 1'b0 || of1 !== 1'b0 || st1 !== 1'b1 || p1 !== 48'h7FFF_FFFF_FFFF) begin
            n_err++; $display("FAIL sat_bubble: v=%b ovf=%b st=%b p=%0h want 0 0 1 7fffffffffff", ov1, of1, st1, p1);
        end
    endtask

    task automatic test_ce();
        drive(1'b1, 5'b00000, 3, 4, 0);
        tick();
        in_valid = 1'b0;
        ce = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (ov0 !== 1'b0 || p0 !== 48'h8000_0000_005A) begin
                n_err++; $display("FAIL ce_freeze_%0d: v=%b p=%0h want 0 80000000005a", i, ov0, p0);
            end
        end
        ce = 1'b1;
        tick();
        n_vec++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL ce_early: out_valid %b want 0", ov0); end
        tick();
        n_vec++; if (ov0 !== 1'b1 || p0 !== 48'd12) begin n_err++; $display("FAIL ce_resume: v=%b p=%0d want 1 12", ov0, p0); end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 5'b00000, 3, 4, 0);
        tick();
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if (p0 !== 48'd0 || ov0 !== 1'b0 || st0 !== 1'b0) begin n_err++; $display("FAIL rst_mid: p=%0d v=%b st=%b want 0 0 0", p0, ov0, st0); end
        n_vec++; if (st1 !== 1'b0 || p1 !== 48'd0) begin n_err++; $display("FAIL rst_sat_sticky: st=%b p=%0h want 0 0", st1, p1); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (ov0 !== 1'b0 || p0 !== 48'd0) begin n_err++; $display("FAIL rst_stale_%0d: v=%b p=%0d want 0 0", i, ov0, p0); end
        end
        drive(1'b1, 5'b00000, 2, 3, 0);
        tick();
        in_valid = 1'b0;
        tick();
        n_vec++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL rst_relat: out_valid %b want 0", ov0); end
        tick();
        n_vec++; if (ov0 !== 1'b1 || p0 !== 48'd6) begin n_err++; $display("FAIL rst_first: v=%b p=%0d want 1 6", ov0, p0); end
    endtask

    task automatic test_cascade();
        pcin = 48'd1000;
        drive(1'b1, 5'b00000, 2, 3, 0);
        tick();
        n_vec++; if (ov2 !== 1'b1 || p2 !== 48'd6 || m2 !== 36'd6) begin n_err++; $display("FAIL fast_mul: v=%b p=%0d m=%0d want 1 6 6", ov2, p2, m2); end
        drive(1'b1, 5'b11100, 2, 3, 0);
        tick();
        n_vec++; if (p2 !== 48'd994 || pc2 !== 48'd994) begin n_err++; $display("FAIL fast_cascade: p=%0d pcout=%0d want 994 994", p2, pc2); end
        in_valid = 1'b0;
        tick();
        n_vec++; if (ov2 !== 1'b0 || p2 !== 48'd994) begin n_err++; $display("FAIL fast_bubble: v=%b p=%0d want 0 994", ov2, p2); end
        n_vec++; if (p0 !== 48'd6) begin n_err++; $display("FAIL dflt_casc_pre: p=%0d want 6", p0); end
        tick();
        n_vec++; if (ov0 !== 1'b1 || p0 !== 48'd994 || pc0 !== 48'd994) begin n_err++; $display("FAIL dflt_cascade: v=%b p=%0d pcout=%0d want 1 994 994", ov0, p0, pc0); end
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; in_valid = 1'b0; opmode = '0;
        a = '0; b = '0; d = '0; c = '0; pcin = '0;
        test_reset();
        test_defaults();
        test_preadd();
        test_accumulate();
        test_saturation();
        test_ce();
        test_reset_midflight();
        test_cascade();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
